// File: rtl/pong_pkg.sv
// Shared pong types and default playfield geometry, common to the ball engine and the renderer.
package pong_pkg;

   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      PLAY   = 2'd1,
      SCORED = 2'd2
   } engine_state_t;

   // One bit per axis: LEFT/UP = 0, RIGHT/DOWN = 1.
   typedef logic dir_t;

   localparam dir_t DIR_LEFT  = 1'b0;
   localparam dir_t DIR_RIGHT = 1'b1;
   localparam dir_t DIR_UP    = 1'b0;
   localparam dir_t DIR_DOWN  = 1'b1;

   localparam int DEF_X_MAX    = 319;
   localparam int DEF_Y_MAX    = 239;
   localparam int DEF_PADDLE_H = 32;

endpackage

// File: rtl/step_timer.sv
// Free-running divider that pulses tick_o once every period_i enabled cycles.
// The count restarts from zero whenever clr_i is high, so the first tick lands period_i cycles after release.
module step_timer #(
   parameter int DIV_W = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [DIV_W-1:0] period_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == period_i - DIV_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ball_engine.sv
// Pong ball physics: position/direction, wall and paddle reflection, per-hit speed-up, scoring and serve flow.
// All motion happens on step_timer ticks; outputs change on the tick edge itself.
module ball_engine
   import pong_pkg::*;
#(
   parameter int X_W         = 9,
   parameter int Y_W         = 8,
   parameter int X_MAX       = DEF_X_MAX,
   parameter int Y_MAX       = DEF_Y_MAX,
   parameter int PADDLE_X_L  = 20,
   parameter int PADDLE_X_R  = 299,
   parameter int PADDLE_H    = DEF_PADDLE_H,
   parameter int DIV_W       = 24,
   parameter int SPEED_INIT  = 1000000,
   parameter int SPEED_STEP  = 50000,
   parameter int SPEED_MIN   = 200000,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           go,
   input  logic [Y_W-1:0] paddle_l_y,
   input  logic [Y_W-1:0] paddle_r_y,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic           serving,
   output logic           in_play,
   output logic           hit,
   output logic           score_l,
   output logic           score_r
);

   localparam logic [X_W-1:0]   X_LAST    = X_W'(X_MAX);
   localparam logic [X_W-1:0]   X_MID     = X_W'(X_MAX / 2);
   localparam logic [X_W-1:0]   X_PL      = X_W'(PADDLE_X_L);
   localparam logic [X_W-1:0]   X_PR      = X_W'(PADDLE_X_R);
   localparam logic [X_W-1:0]   X_PL_OUT  = X_W'(PADDLE_X_L + 1);
   localparam logic [X_W-1:0]   X_PR_OUT  = X_W'(PADDLE_X_R - 1);
   localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0]   Y_LAST_M1 = Y_W'(Y_MAX - 1);
   localparam logic [Y_W-1:0]   Y_MID     = Y_W'(Y_MAX / 2);
   localparam logic [Y_W:0]     PH_M1     = (Y_W + 1)'(PADDLE_H - 1);
   localparam logic [Y_W-1:0]   ZONE_TOP  = Y_W'(PADDLE_H / 3);
   localparam logic [Y_W-1:0]   ZONE_BOT  = Y_W'(PADDLE_H - PADDLE_H / 3);
   localparam logic [DIV_W-1:0] P_INIT    = DIV_W'(SPEED_INIT);
   localparam logic [DIV_W-1:0] P_STEP    = DIV_W'(SPEED_STEP);
   localparam logic [DIV_W-1:0] P_MIN     = DIV_W'(SPEED_MIN);
   localparam logic [DIV_W:0]   P_SAT_AT  = {1'b0, P_MIN} + {1'b0, P_STEP};
   localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   engine_state_t     state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   dir_t              dx_q, dx_d, dy_q, dy_d;
   logic              yen_q, yen_d;
   logic [DIV_W-1:0]  period_q, period_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              hit_q, hit_d, score_l_q, score_l_d, score_r_q, score_r_d;

   logic              tick;
   logic [Y_W:0]      y_ext, pl_ext, pr_ext;
   logic              in_l, in_r, hit_l, hit_r;
   logic [Y_W-1:0]    offset;

   // One extra bit so a paddle hanging off the bottom clips instead of wrapping.
   assign y_ext  = {1'b0, y_q};
   assign pl_ext = {1'b0, paddle_l_y};
   assign pr_ext = {1'b0, paddle_r_y};
   assign in_l   = (y_ext >= pl_ext) && (y_ext <= pl_ext + PH_M1);
   assign in_r   = (y_ext >= pr_ext) && (y_ext <= pr_ext + PH_M1);
   assign hit_l  = (dx_q == DIR_LEFT) && (x_q == X_PL) && in_l;
   assign hit_r  = (dx_q == DIR_RIGHT) && (x_q == X_PR) && in_r;
   assign offset = y_q - (hit_l ? paddle_l_y : paddle_r_y);

   step_timer #(.DIV_W(DIV_W)) u_step_timer (
      .clock    (clock),
      .reset    (reset),
      .en_i     (state_q == PLAY),
      .clr_i    (state_q != PLAY),
      .period_i (period_q),
      .tick_o   (tick)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      yen_d     = yen_q;
      period_d  = period_q;
      hold_d    = '0;
      hit_d     = 1'b0;
      score_l_d = 1'b0;
      score_r_d = 1'b0;

      case (state_q)
         SERVE: begin
            if (go) state_d = PLAY;
         end
         PLAY: begin
            if (tick) begin
               // Leaving dx_q untouched on a score makes the next serve head toward the conceding side.
               if ((dx_q == DIR_LEFT) && (x_q == '0)) begin
                  score_r_d = 1'b1;
                  state_d   = SCORED;
               end else if ((dx_q == DIR_RIGHT) && (x_q == X_LAST)) begin
                  score_l_d = 1'b1;
                  state_d   = SCORED;
               end else begin
                  if (hit_l || hit_r) begin
                     hit_d = 1'b1;
                     dx_d  = ~dx_q;
                     x_d   = hit_l ? X_PL_OUT : X_PR_OUT;
                     if ({1'b0, period_q} > P_SAT_AT) period_d = period_q - P_STEP;
                     else                             period_d = P_MIN;
                     if (offset < ZONE_TOP) begin
                        yen_d = 1'b1;
                        dy_d  = DIR_UP;
                     end else if (offset >= ZONE_BOT) begin
                        yen_d = 1'b1;
                        dy_d  = DIR_DOWN;
                     end else begin
                        yen_d = 1'b0;
                     end
                  end else begin
                     x_d = (dx_q == DIR_LEFT) ? x_q - X_W'(1) : x_q + X_W'(1);
                  end
                  // Vertical step uses the post-hit direction so wall and paddle reflect together.
                  if (yen_d) begin
                     if (dy_d == DIR_UP) begin
                        if (y_q == '0) begin
                           dy_d = DIR_DOWN;
                           y_d  = Y_W'(1);
                        end else begin
                           y_d = y_q - Y_W'(1);
                        end
                     end else begin
                        if (y_q == Y_LAST) begin
                           dy_d = DIR_UP;
                           y_d  = Y_LAST_M1;
                        end else begin
                           y_d = y_q + Y_W'(1);
                        end
                     end
                  end
               end
            end
         end
         SCORED: begin
            if (hold_q == HOLD_LAST) begin
               state_d  = SERVE;
               x_d      = X_MID;
               y_d      = Y_MID;
               period_d = P_INIT;
               yen_d    = 1'b1;
               dy_d     = DIR_DOWN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = SERVE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= SERVE;
         x_q       <= X_MID;
         y_q       <= Y_MID;
         dx_q      <= DIR_RIGHT;
         dy_q      <= DIR_DOWN;
         yen_q     <= 1'b1;
         period_q  <= P_INIT;
         hold_q    <= '0;
         hit_q     <= 1'b0;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         yen_q     <= yen_d;
         period_q  <= period_d;
         hold_q    <= hold_d;
         hit_q     <= hit_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
      end
   end

   assign ball_x  = x_q;
   assign ball_y  = y_q;
   assign serving = (state_q == SERVE);
   assign in_play = (state_q == PLAY);
   assign hit     = hit_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
Parametrised successor to the pong ball-physics block. It owns ball position, velocity and direction for the playfield. It handles wall bounces, paddle collisions with hit-zone-dependent angle, per-hit speed-up and scoring, and runs a serve/play/score state machine. It sits between the paddle controllers and the VGA renderer, which reads ball_x/ball_y directly.

Parameters:
X_W, 9, width of ball_x / paddle-independent x coordinates
Y_W, 8, width of ball_y, paddle_l_y, paddle_r_y
X_MAX, 319, rightmost legal ball column
Y_MAX, 239, bottom legal ball row
PADDLE_X_L, 20, column of left paddle face
PADDLE_X_R, 299, column of right paddle face
PADDLE_H, 32, paddle height in rows
DIV_W, 24, width of step-period counter
SPEED_INIT, 1000000, clock cycles per pixel step at serve
SPEED_STEP, 50000, period decrement per paddle hit
SPEED_MIN, 200000, lower saturation bound of period
HOLD_CYCLES, 25000000, cycles the ball is frozen after a point

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  serve request; honoured only in SERVE
paddle_l_y  in  Y_W  top row of left paddle
paddle_r_y  in  Y_W  top row of right paddle
ball_x  out  X_W  ball column
ball_y  out  Y_W  ball row
serving  out  1  high while in SERVE
in_play  out  1  high while in PLAY
hit  out  1  one-cycle pulse on any paddle hit
score_l  out  1  one-cycle pulse when the left player scores
score_r  out  1  one-cycle pulse when the right player scores

Behaviour:
- One clock is used throughout. Reset is synchronous and active-high, on ports clock/reset. On reset the next edge enters SERVE.
- Reset values:
  - ball_x=X_MAX/2 (159), ball_y=Y_MAX/2 (119).
  - serving=1, in_play=0, hit=score_l=score_r=0.
  - period=SPEED_INIT, dir_x=right, dir_y=down, y_en=1.
- States are SERVE, PLAY and SCORED.
  - SERVE -> PLAY on go. Entering PLAY clears the step counter.
  - PLAY -> SCORED when the ball exits either side (see "Out" below).
  - SCORED -> SERVE after HOLD_CYCLES cycles. Entering SERVE recentres the ball, sets period=SPEED_INIT, y_en=1 and dir_y=down.
- go is ignored in PLAY and SCORED. Reset mid-play forces SERVE with reset values on the next edge.
- Step timing:
  - The counter runs only in PLAY and counts 0..period-1.
  - tick asserts on count==period-1, then the counter wraps to 0.
  - The first tick occurs period cycles after the PLAY entry edge.
- Motion, evaluated on tick only:
  - x moves ±1 per tick.
  - y moves ±1 per tick when y_en=1.
  - Outputs update on the same edge as the tick. There is no extra latency.
- Wall: if a y step would pass 0 (moving up) or Y_MAX (moving down), flip dir_y and step 1 the other way on that tick. ball_y never leaves 0..Y_MAX.
- Paddle hit condition:
  - Left: moving left, ball_x==PADDLE_X_L, and paddle_l_y <= ball_y <= paddle_l_y+PADDLE_H-1.
  - Right: mirror of the left rule, using PADDLE_X_R and paddle_r_y.
  - Paddle inputs are sampled on the tick cycle.
- Paddle hit response:
  - Flip dir_x; the ball moves to PADDLE_X_L+1 (or PADDLE_X_R-1) on that tick.
  - Pulse hit.
  - period <= max(period-SPEED_STEP, SPEED_MIN), saturating with no underflow.
- Hit zone: offset = ball_y - paddle_y.
  - offset < PADDLE_H/3: y_en=1, dir_y=up.
  - offset >= PADDLE_H-PADDLE_H/3: y_en=1, dir_y=down.
  - Otherwise: y_en=0 (horizontal return).
- Miss: the ball keeps travelling past the paddle column.
- Out:
  - Tick while moving left with ball_x==0: score_r pulses, enter SCORED.
  - Tick while moving right with ball_x==X_MAX: score_l pulses, enter SCORED.
  - Position freezes at the last value.
  - The next serve dir_x points toward the player who conceded.
- Simultaneous wall and paddle on one tick: both reflections apply in the same cycle, and hit still pulses.
- Paddle inputs whose bottom row (y+PADDLE_H-1) exceeds Y_MAX are clipped by the range compare. No wrap is allowed: the compare uses Y_W+1 bits.

Decomposition:
- Shared package pong_pkg holds:
  - the engine_state_t enum (SERVE, PLAY, SCORED);
  - the dir_t typedef (1 bit, LEFT/UP=0, RIGHT/DOWN=1);
  - default geometry constants shared with the renderer (X_MAX, Y_MAX, PADDLE_H).
- One sub-module, step_timer, is natural. It has DIV_W-bit period input, enable, clear and one-cycle tick output, and replaces per-axis threshold counters.

Test Plan:
- Reset, then idle 10 cycles with go=0 -> ball_x=159, ball_y=119, serving=1, in_play=0, no pulses.
- SPEED_INIT=4, go pulse -> in_play=1 next edge; ball_x=160, ball_y=120 exactly 4 cycles later; 161/121 at 8 cycles.
- Ball moving down reaches ball_y=239 -> next tick ball_y=238, dir_y=up; ball_y never reads 240.
- Left paddle at paddle_l_y=100, ball at x=20, y=101 moving left -> hit pulse, ball_x=21, dir_y=up, period 4->3 (SPEED_STEP=1, SPEED_MIN=2). A third hit keeps period=2.
- Middle-zone hit (ball_y=paddle_l_y+15) -> y_en=0; ball_y constant over the following 20 ticks.
- Paddle_l_y=0 and ball misses at y=200 -> ball reaches x=0; next tick score_r pulses once, state SCORED, HOLD_CYCLES later serving=1, ball recentred, reset asserted mid-PLAY returns to SERVE in 1 edge.
